// File: rtl/iob_sp_ram_be.sv
// Single-port synchronous RAM with byte strobes, 1/2-cycle read latency and a zero-fill sweep.
// Optional per-byte even parity storage and a parity_err output: define IOB_SP_RAM_BE_PARITY_EN.
module iob_sp_ram_be #(
  parameter     FILE     = "none",
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  input  logic                  clr,
  output logic                  busy
`ifdef IOB_SP_RAM_BE_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  if ((DATA_W % 8) != 0 || (RD_LAT != 1 && RD_LAT != 2)) begin : g_bad_param
    $error("iob_sp_ram_be: DATA_W must be a multiple of 8 and RD_LAT must be 1 or 2");
  end

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) begin
      p[i] = ^w[8*i +: 8];
    end
    return p;
  endfunction

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                acc, wr_acc, rd_acc;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   merged;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign busy    = (state_q == CLEAR);
  // clr in IDLE takes priority over a coincident access.
  assign acc     = en & ~busy & ~clr;
  assign wr_acc  = acc & (|we);
  assign rd_acc  = acc & ~(|we);
  assign rd_word = mem[addr];
  assign merged  = merge_bytes(rd_word, din, we);

  // Clear sequencer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      else                  clr_cnt <= '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr) state_d = CLEAR;
      CLEAR:   if (&clr_cnt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Storage array: the sweep owns the port while busy
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

`ifdef IOB_SP_RAM_BE_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] din_par;
  logic          rd_perr;

  assign din_par = byte_par(din);
  assign rd_perr = |(byte_par(rd_word) ^ par_mem[addr]);

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      par_mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (we[i]) par_mem[addr][i] <= din_par[i];
      end
    end
  end
`endif

  // Stage 1: array read or write-first merged word
  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  logic              perr_p1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      perr_p1 <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      perr_p1 <= 1'b0;
      if (rd_acc) begin
        data_p1 <= rd_word;
        vld_p1  <= 1'b1;
`ifdef IOB_SP_RAM_BE_PARITY_EN
        perr_p1 <= rd_perr;
`endif
      end else if (wr_acc && RDW_MODE != 0) begin
        data_p1 <= merged;
        vld_p1  <= 1'b1;
      end
    end
  end

  // Stage 2: optional output register, loads only on valid data
  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] data_p2;
    logic              vld_p2;
    logic              perr_p2;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        data_p2 <= '0;
        vld_p2  <= 1'b0;
        perr_p2 <= 1'b0;
      end else begin
        vld_p2  <= vld_p1;
        perr_p2 <= vld_p1 & perr_p1;
        if (vld_p1) data_p2 <= data_p1;
      end
    end

    assign dout       = data_p2;
    assign dout_valid = vld_p2;
`ifdef IOB_SP_RAM_BE_PARITY_EN
    assign parity_err = perr_p2;
`else
    logic unused_perr;
    assign unused_perr = perr_p2;
`endif
  end else begin : g_lat1
    assign dout       = data_p1;
    assign dout_valid = vld_p1;
`ifdef IOB_SP_RAM_BE_PARITY_EN
    assign parity_err = perr_p1;
`else
    logic unused_perr;
    assign unused_perr = perr_p1;
`endif
  end

endmodule

// File: tb/tb_iob_sp_ram_be.sv
// Directed bench for iob_sp_ram_be: three instances (lat1/no-change, lat2/no-change, lat1/write-first)
// share one stimulus stream; ADDR_W=4 keeps the clear sweep at 16 cycles.
module tb_iob_sp_ram_be;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  we = '0;
  logic [3:0]  addr = '0;
  logic [31:0] din = '0;

  logic [31:0] a_dout, b_dout, c_dout;
  logic        a_vld, b_vld, c_vld;
  logic        a_busy, b_busy, c_busy;
`ifdef IOB_SP_RAM_BE_PARITY_EN
  logic        a_perr, b_perr, c_perr;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  iob_sp_ram_be #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0)) dut_a (
    .clk(clk), .resetn(resetn), .en(en), .we(we), .addr(addr), .din(din),
    .dout(a_dout), .dout_valid(a_vld), .clr(clr), .busy(a_busy)
`ifdef IOB_SP_RAM_BE_PARITY_EN
    , .parity_err(a_perr)
`endif
  );

  iob_sp_ram_be #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(0)) dut_b (
    .clk(clk), .resetn(resetn), .en(en), .we(we), .addr(addr), .din(din),
    .dout(b_dout), .dout_valid(b_vld), .clr(clr), .busy(b_busy)
`ifdef IOB_SP_RAM_BE_PARITY_EN
    , .parity_err(b_perr)
`endif
  );

  iob_sp_ram_be #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(1)) dut_c (
    .clk(clk), .resetn(resetn), .en(en), .we(we), .addr(addr), .din(din),
    .dout(c_dout), .dout_valid(c_vld), .clr(clr), .busy(c_busy)
`ifdef IOB_SP_RAM_BE_PARITY_EN
    , .parity_err(c_perr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic e, input logic [3:0] w, input logic [3:0] a, input logic [31:0] d);
    en = e; we = w; addr = a; din = d;
    tick();
  endtask

  initial begin
    int  n_busy;
    logic vld_seen;

    // Reset state
    tick(); tick();
    chk("rst_a_dout", a_dout, 32'h0);
    chk("rst_a_vld", {31'b0, a_vld}, 32'h0);
    chk("rst_a_busy", {31'b0, a_busy}, 32'h0);
    chk("rst_b_dout", b_dout, 32'h0);
    chk("rst_c_vld", {31'b0, c_vld}, 32'h0);
    resetn = 1'b1;
    tick();

    // Byte-strobe write then read
    acc(1, 4'hF, 4'd5, 32'hDEADBEEF);
    chk("wf_full_c_dout", c_dout, 32'hDEADBEEF);
    chk("wf_full_c_vld", {31'b0, c_vld}, 32'h1);
    chk("nc_write_a_vld", {31'b0, a_vld}, 32'h0);
    acc(1, 4'b0101, 4'd5, 32'h11223344);
    chk("wf_merge_c_dout", c_dout, 32'hDE22BE44);
    acc(1, 4'h0, 4'd5, 32'h0);
    chk("rd5_a_dout", a_dout, 32'hDE22BE44);
    chk("rd5_a_vld", {31'b0, a_vld}, 32'h1);
    chk("rd5_b_vld_early", {31'b0, b_vld}, 32'h0);
    acc(0, 4'h0, 4'd0, 32'h0);
    chk("rd5_a_vld_pulse", {31'b0, a_vld}, 32'h0);
    chk("rd5_a_dout_hold", a_dout, 32'hDE22BE44);
    chk("rd5_b_dout", b_dout, 32'hDE22BE44);
    chk("rd5_b_vld", {31'b0, b_vld}, 32'h1);

    // Back-to-back reads at latency 2
    acc(1, 4'hF, 4'd1, 32'h11111111);
    acc(1, 4'hF, 4'd2, 32'h22222222);
    acc(1, 4'hF, 4'd3, 32'h33333333);
    acc(1, 4'h0, 4'd1, 32'h0);
    chk("b2b_a_r1", a_dout, 32'h11111111);
    chk("b2b_b_noval", {31'b0, b_vld}, 32'h0);
    acc(1, 4'h0, 4'd2, 32'h0);
    chk("b2b_b_r1", b_dout, 32'h11111111);
    chk("b2b_b_v1", {31'b0, b_vld}, 32'h1);
    acc(1, 4'h0, 4'd3, 32'h0);
    chk("b2b_b_r2", b_dout, 32'h22222222);
    chk("b2b_b_v2", {31'b0, b_vld}, 32'h1);
    acc(0, 4'h0, 4'd0, 32'h0);
    chk("b2b_b_r3", b_dout, 32'h33333333);
    chk("b2b_b_v3", {31'b0, b_vld}, 32'h1);
    acc(0, 4'h0, 4'd0, 32'h0);
    chk("b2b_b_hold", b_dout, 32'h33333333);
    chk("b2b_b_vend", {31'b0, b_vld}, 32'h0);

    // Read-during-write modes
    acc(1, 4'hF, 4'd7, 32'hAAAAAAAA);
    acc(0, 4'h0, 4'd0, 32'h0);
    acc(1, 4'b0001, 4'd7, 32'h000000BB);
    chk("rdw0_a_dout", a_dout, 32'h33333333);
    chk("rdw0_a_vld", {31'b0, a_vld}, 32'h0);
    chk("rdw1_c_dout", c_dout, 32'hAAAAAABB);
    chk("rdw1_c_vld", {31'b0, c_vld}, 32'h1);
    acc(1, 4'h0, 4'd7, 32'h0);
    chk("rdw_rd7_a", a_dout, 32'hAAAAAABB);

    // Clear sweep with coincident access, accesses and second clr while busy
    for (int i = 0; i < 16; i++) acc(1, 4'hF, i[3:0], 32'hFFFFFFFF);
    clr = 1'b1;
    acc(1, 4'hF, 4'd0, 32'h12345678);
    clr = 1'b0;
    chk("clr_busy", {31'b0, a_busy}, 32'h1);
    chk("clr_drop_c_vld", {31'b0, c_vld}, 32'h0);
    chk("clr_drop_a_vld", {31'b0, a_vld}, 32'h0);
    n_busy = 1;
    vld_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      en = 1'b1; we = 4'hF; addr = i[3:0]; din = 32'h55555555;
      clr = (i == 5);
      tick();
      vld_seen = vld_seen | a_vld | b_vld | c_vld;
      if (a_busy) n_busy++;
      else break;
    end
    en = 1'b0; clr = 1'b0; we = 4'h0;
    chk("clr_busy_cycles", n_busy, 32'd16);
    chk("clr_no_valid", {31'b0, vld_seen}, 32'h0);
    chk("clr_busy_b", {31'b0, b_busy}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      acc(1, 4'h0, i[3:0], 32'h0);
      chk($sformatf("clr_rd%0d", i), a_dout, 32'h0);
    end

    // Reset in the middle of a sweep
    for (int i = 0; i < 16; i++) acc(1, 4'hF, i[3:0], 32'hFFFFFFFF);
    en = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, a_busy}, 32'h0);
    chk("mid_rst_dout", a_dout, 32'h0);
    chk("mid_rst_vld", {31'b0, a_vld}, 32'h0);
    tick();
    resetn = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      acc(1, 4'h0, i[3:0], 32'h0);
      chk($sformatf("part_rd%0d", i), a_dout, (i < 6) ? 32'h0 : 32'hFFFFFFFF);
    end

`ifdef IOB_SP_RAM_BE_PARITY_EN
    acc(1, 4'hF, 4'd2, 32'h01020304);
    acc(1, 4'hF, 4'd3, 32'h01020304);
    acc(1, 4'h0, 4'd3, 32'h0);
    chk("par_ok", {31'b0, a_perr}, 32'h0);
    dut_a.par_mem[2][0] = ~dut_a.par_mem[2][0];
    acc(1, 4'h0, 4'd2, 32'h0);
    chk("par_err", {31'b0, a_perr}, 32'h1);
    acc(1, 4'h0, 4'd3, 32'h0);
    chk("par_err_once", {31'b0, a_perr}, 32'h0);
`endif

    acc(0, 4'h0, 4'd0, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
